// File: rtl/way_encode_lru.sv
// way_encode_lru
//   Encodes the 2-way one-hot tag-match vector into a binary way index,
//   keeps one LRU bit per set to pick the victim on a miss, and runs a
//   flush sequencer that walks every set clearing its LRU bit.
//
// Ports
//   clk, reset    : clock; asynchronous active-high reset
//   req_valid     : lookup strobe, accepted when req_ready=1 and no flush_start
//   req_ready     : high in IDLE
//   req_set       : set index of the lookup
//   hit_onehot    : tag match vector, bit0=way0, bit1=way1
//   flush_start   : pulse that starts an LRU flush (wins over req_valid)
//   busy          : high while flushing
//   resp_valid    : one-cycle response strobe, 1 cycle after acceptance
//   resp_hit      : exactly one way matched
//   resp_way      : hit way on a hit, victim way on a miss, 0 on error
//   resp_err      : both ways matched
module way_encode_lru #(
  parameter int SET_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_BITS-1:0] req_set,
  input  logic [1:0]          hit_onehot,
  input  logic                flush_start,
  output logic                busy,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic                resp_way,
  output logic                resp_err
);

  localparam int NSETS = 2**SET_BITS;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_FLUSH = 1'b1;

  logic                state;
  logic [SET_BITS-1:0] cnt;
  logic                lru [NSETS];

  logic accept;
  logic hit_d, err_d, way_d;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state == ST_FLUSH);

  // flush_start takes priority: a request in the same cycle is not accepted
  assign accept = req_valid & req_ready & ~flush_start;

  // LRU array is read combinationally; a same-set request in the next cycle
  // sees the bit written at the accepting edge, so no forwarding is needed.
  always_comb begin
    hit_d = 1'b0;
    err_d = 1'b0;
    way_d = 1'b0;
    case (hit_onehot)
      2'b01: hit_d = 1'b1;
      2'b10: begin hit_d = 1'b1; way_d = 1'b1; end
      2'b00: way_d = lru[req_set];
      default: err_d = 1'b1;
    endcase
  end

  // Flush FSM and counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (flush_start) begin
          state <= ST_FLUSH;
          cnt   <= '0;
        end
        default: begin
          cnt <= cnt + 1'b1;  // wraps to 0 on the exit cycle
          if (cnt == {SET_BITS{1'b1}}) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Response registers: strobe for one cycle, data held until the next response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_way   <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        resp_hit <= hit_d;
        resp_way <= way_d;
        resp_err <= err_d;
      end
    end
  end

  // Per-set LRU bit. Hit or miss both make the returned way MRU, so the
  // new LRU is the other way; an error leaves the bit alone.
  for (genvar s = 0; s < NSETS; s++) begin : g_set
    logic clr, wr;
    assign clr = busy && (cnt == SET_BITS'(s));
    assign wr  = accept && !err_d && (req_set == SET_BITS'(s));
    always_ff @(posedge clk or posedge reset) begin
      if (reset)    lru[s] <= 1'b0;
      else if (clr) lru[s] <= 1'b0;
      else if (wr)  lru[s] <= ~way_d;
    end
  end

endmodule

// File: tb/tb_way_encode_lru.sv
module tb_way_encode_lru;

  localparam int SB = 4;
  localparam int NS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [SB-1:0] req_set;
  logic [1:0]    hit_onehot;
  logic          flush_start;
  logic          busy, resp_valid, resp_hit, resp_way, resp_err;

  way_encode_lru #(.SET_BITS(SB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .hit_onehot(hit_onehot), .flush_start(flush_start),
    .busy(busy), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_way(resp_way), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks LRU as "which way to evict next" and a flush as a number of
  // remaining set-clear cycles.
  bit m_lru [NS];
  int m_flush_left;
  int m_flush_idx;
  bit m_rv, m_hit, m_way, m_err;

  task automatic model_reset();
    foreach (m_lru[i]) m_lru[i] = 0;
    m_flush_left = 0; m_flush_idx = 0;
    m_rv = 0; m_hit = 0; m_way = 0; m_err = 0;
  endtask

  task automatic model_clock(input bit v, input int set, input bit [1:0] h, input bit fs);
    m_rv = 0;
    if (m_flush_left > 0) begin
      m_lru[m_flush_idx] = 0;
      m_flush_idx++;
      m_flush_left--;
    end else if (fs) begin
      m_flush_left = NS;
      m_flush_idx  = 0;
    end else if (v) begin
      int ones = h[0] + h[1];
      m_rv = 1;
      m_err = (ones == 2);
      m_hit = (ones == 1);
      if (ones == 1)      m_way = h[1];
      else if (ones == 0) m_way = m_lru[set];
      else                m_way = 0;
      if (ones < 2) m_lru[set] = !m_way;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".resp_valid"}, resp_valid, m_rv);
    check({tag, ".resp_hit"},   resp_hit,   m_hit);
    check({tag, ".resp_way"},   resp_way,   m_way);
    check({tag, ".resp_err"},   resp_err,   m_err);
    check({tag, ".busy"},       busy,       m_flush_left > 0);
    check({tag, ".req_ready"},  req_ready,  m_flush_left == 0);
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit later.
  task automatic step(input bit v, input int set, input bit [1:0] h, input bit fs);
    @(negedge clk);
    req_valid = v; req_set = SB'(set); hit_onehot = h; flush_start = fs;
    @(posedge clk);
    #1;
    model_clock(v, set, h, fs);
    req_valid = 0; flush_start = 0;
  endtask

  typedef struct {
    int       set;
    bit [1:0] h;
    bit       e_hit;
    bit       e_way;
    bit       e_err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{3, 2'b00, 0, 0, 0};  // first miss: victim 0
    vecs[1] = '{3, 2'b00, 0, 1, 0};  // same set next cycle sees updated LRU
    vecs[2] = '{5, 2'b00, 0, 0, 0};
    vecs[3] = '{5, 2'b10, 1, 1, 0};
    vecs[4] = '{5, 2'b00, 0, 0, 0};  // victim is non-hit way 0
    vecs[5] = '{7, 2'b00, 0, 0, 0};  // lru[7] -> 1
    vecs[6] = '{7, 2'b11, 0, 0, 1};  // error leaves lru[7]
    vecs[7] = '{7, 2'b00, 0, 1, 0};  // prior victim 1
    vecs[8] = '{9, 2'b01, 1, 0, 0};
    vecs[9] = '{9, 2'b00, 0, 1, 0};

    reset = 1; req_valid = 0; req_set = 0; hit_onehot = 0; flush_start = 0;
    model_reset();
    #12;
    check("rst.resp_valid", resp_valid, 0);
    check("rst.resp_hit",   resp_hit,   0);
    check("rst.resp_way",   resp_way,   0);
    check("rst.resp_err",   resp_err,   0);
    check("rst.busy",       busy,       0);
    check("rst.req_ready",  req_ready,  1);
    @(negedge clk); reset = 0;

    // ---- directed table, back-to-back ----
    for (int i = 0; i < 10; i++) begin
      step(1, vecs[i].set, vecs[i].h, 0);
      check($sformatf("vec%0d.valid", i), resp_valid, 1);
      check($sformatf("vec%0d.hit", i),   resp_hit,   vecs[i].e_hit);
      check($sformatf("vec%0d.way", i),   resp_way,   vecs[i].e_way);
      check($sformatf("vec%0d.err", i),   resp_err,   vecs[i].e_err);
    end
    step(0, 0, 2'b00, 0);
    check("strobe_one_cycle", resp_valid, 0);
    check("hold_way", resp_way, 1);

    // ---- randomized against the model ----
    for (int i = 0; i < 400; i++) begin
      bit v  = ($urandom_range(0, 3) != 0);
      bit fs = ($urandom_range(0, 59) == 0);
      step(v, $urandom_range(0, NS-1), 2'($urandom), fs);
      check_model($sformatf("rnd%0d", i));
    end
    while (m_flush_left > 0) step(0, 0, 2'b00, 0);

    // ---- flush with simultaneous request ----
    for (int s = 0; s < NS; s += 2) step(1, s, 2'b01, 0);  // lru[s]=1 for even sets
    step(1, 4, 2'b00, 1);
    check("flush.req_dropped", resp_valid, 0);
    check("flush.busy0", busy, 1);
    check("flush.ready0", req_ready, 0);
    for (int c = 1; c < NS; c++) begin
      step(1, c, 2'b00, (c == 3));  // requests dropped, re-pulse ignored
      check($sformatf("flush.busy%0d", c), busy, 1);
      check($sformatf("flush.ready%0d", c), req_ready, 0);
      check($sformatf("flush.novalid%0d", c), resp_valid, 0);
    end
    step(0, 0, 2'b00, 0);
    check("flush.done_busy", busy, 0);
    check("flush.done_ready", req_ready, 1);
    for (int s = 0; s < NS; s++) begin
      step(1, s, 2'b00, 0);
      check($sformatf("postflush.way%0d", s), resp_way, 0);
    end

    // ---- reset at flush cycle 6 ----
    for (int s = 0; s < NS; s++) step(1, s, 2'b01, 0);  // all lru=1
    step(0, 0, 2'b00, 1);
    for (int c = 1; c < 6; c++) step(0, 0, 2'b00, 0);
    #2 reset = 1;
    #1;
    model_reset();
    check("rstflush.busy", busy, 0);
    check("rstflush.ready", req_ready, 1);
    check("rstflush.valid", resp_valid, 0);
    @(negedge clk); reset = 0;

    // ---- reset during a pending response ----
    step(1, 2, 2'b10, 0);
    check("pend.valid_before", resp_valid, 1);
    #1 reset = 1;
    #1;
    model_reset();
    check("pend.valid", resp_valid, 0);
    check("pend.hit", resp_hit, 0);
    check("pend.busy", busy, 0);
    check("pend.ready", req_ready, 1);
    @(negedge clk); reset = 0;
    for (int s = 0; s < NS; s++) begin
      step(1, s, 2'b00, 0);
      check($sformatf("postrst.way%0d", s), resp_way, 0);
      check_model($sformatf("postrst%0d", s));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
